uart_rx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_rx_buffered.sv | 123 ++++++++++++
 tb/tb_uart_rx_buffered.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the baud divider calculation.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   // Oversample tick divider, never below 1 so very fast baud rates still tick.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = clk_hz / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty and simultaneous
// push/pop; shared by the RX path and the future TX queue.
module uart_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 16x oversampling deframer feeding a small FWFT FIFO,
// with sticky overflow / framing-error flags and a level receive interrupt.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600,
   parameter int DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       irq,
   output logic       overflow,
   output logic       frame_err
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

   rx_state_t   state, state_nxt;
   logic        rx_meta, rxs, rxs_prev;
   logic [TW-1:0] tick_cnt;
   logic        tick;
   logic [3:0]  samp_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        sample_start, sample_bit, sample_stop;
   logic        push, ferr_evt, ovf_evt;
   logic        fifo_full, fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rx;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   assign tick = (state != IDLE) && (tick_cnt == TW'(DIV - 1));

   // Counters are parked at zero in IDLE so every character starts phase-aligned
   // to its own start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         samp_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (state == IDLE) begin
         tick_cnt <= '0;
         samp_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) samp_cnt <= sample_start ? 4'd0 : samp_cnt + 1'b1;
         if (sample_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {rxs, shreg[7:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!rxs && rxs_prev)               state_nxt = START;
         START: if (sample_start)                    state_nxt = rxs ? IDLE : DATA;
         DATA:  if (sample_bit && bit_cnt == 3'd7)   state_nxt = STOP;
         STOP:  if (sample_stop)                     state_nxt = IDLE;
         default:                                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sample_start = (state == START) && tick && (samp_cnt == 4'(MID_SAMPLE - 1));
      sample_bit   = (state == DATA)  && tick && (samp_cnt == 4'(OVERSAMPLE - 1));
      sample_stop  = (state == STOP)  && tick && (samp_cnt == 4'(OVERSAMPLE - 1));
      push         = sample_stop && rxs;
      ferr_evt     = sample_stop && !rxs;
   end

   // A full FIFO is never empty, so rd_en here always frees a slot.
   assign ovf_evt = push && fifo_full && !rd_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= ovf_evt  | (overflow  & ~clr_err);
         frame_err <= ferr_evt | (frame_err & ~clr_err);
      end
   end

   uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (shreg),
      .pop     (rd_en),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rx_valid = !fifo_empty;
   assign irq      = rx_valid;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: DIV=10, 160 clocks per bit.
module tb_uart_rx_buffered;

   localparam int BIT_CYC = 160;

   logic       clk = 1'b0;
   logic       reset, rx, rd_en, clr_err;
   logic [7:0] rd_data;
   logic       rx_valid, irq, overflow, frame_err;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   uart_rx_buffered #(.CLK_HZ(1_600_000), .BAUD(10_000), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .rx_valid  (rx_valid),
      .irq       (irq),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted pop must present the oldest expected byte.
   always @(negedge clk) begin
      if (rd_en && rx_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pop_unexpected: got %h expected none at %0t", rd_data, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rd_data !== mon_exp) begin
               fails++;
               $display("FAIL pop_data: got %h expected %h at %0t", rd_data, mon_exp, $time);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the stop bit has elapsed.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (BIT_CYC) @(posedge clk);
         #1;
      end
   endtask

   task automatic pop_one();
      int n;
      n = 0;
      while (!rx_valid && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!rx_valid) begin
         tests++;
         fails++;
         $display("FAIL pop_timeout: rx_valid 0 expected 1 at %0t", $time);
      end else begin
         rd_en = 1'b1;
         @(posedge clk);
         #1;
         rd_en = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      idle(1);
   endtask

   initial begin
      reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
      idle(3);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_irq", irq, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      idle(20);

      // Single byte with latency window around the expected rise (~1523 cycles)
      exp_q.push_back(8'hA5);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            repeat (1520) @(posedge clk);
            @(negedge clk);
            check("lat_before", rx_valid, 0);
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("lat_after", rx_valid, 1);
            check("irq_set", irq, 1);
            check("head_a5", rd_data, 8'hA5);
         end
      join
      pop_one();
      idle(2);
      check("empty_after_pop", rx_valid, 0);
      check("irq_clear", irq, 0);

      // Short low glitch is rejected
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(200);
      check("glitch_valid", rx_valid, 0);
      check("glitch_ferr", frame_err, 0);
      check("glitch_ovf", overflow, 0);

      // Framing error, clear, then a clean character
      send_byte(8'h3C, 1'b0);
      rx = 1'b1;
      idle(20);
      check("ferr_set", frame_err, 1);
      check("ferr_no_push", rx_valid, 0);
      pulse_clr();
      check("ferr_clear", frame_err, 0);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      idle(20);
      pop_one();
      idle(2);

      // Five back-to-back bytes into a 4-deep FIFO
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back(8'(b));
         send_byte(8'(b), 1'b1);
      end
      idle(20);
      check("ovf_set", overflow, 1);
      check("ovf_valid", rx_valid, 1);
      check("ovf_head", rd_data, 8'h01);
      repeat (4) pop_one();
      idle(2);
      check("ovf_drained", rx_valid, 0);
      pulse_clr();
      check("ovf_clear", overflow, 0);

      // Pop coinciding with the push into a full FIFO
      for (int b = 1; b <= 4; b++) begin
         exp_q.push_back(8'(b));
         send_byte(8'(b), 1'b1);
      end
      exp_q.push_back(8'h06);
      fork
         send_byte(8'h06, 1'b1);
         begin
            repeat (1522) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
         end
      join
      idle(20);
      check("simul_no_ovf", overflow, 0);
      check("simul_valid", rx_valid, 1);
      repeat (4) pop_one();
      idle(2);
      check("simul_drained", rx_valid, 0);

      // Reset during data bit 4 with a byte already queued
      send_byte(8'h11, 1'b1);
      idle(10);
      check("pre_rst_queued", rx_valid, 1);
      fork
         send_byte(8'h55, 1'b1);
         begin
            repeat (5 * BIT_CYC + BIT_CYC / 2) @(posedge clk);
            #1 reset = 1'b1;
            #1;
            check("mid_rst_rd_data", rd_data, 8'h00);
            check("mid_rst_valid", rx_valid, 0);
            check("mid_rst_irq", irq, 0);
            check("mid_rst_ovf", overflow, 0);
            check("mid_rst_ferr", frame_err, 0);
         end
      join
      reset = 1'b0;
      idle(50);
      check("post_rst_valid", rx_valid, 0);
      exp_q.push_back(8'h81);
      send_byte(8'h81, 1'b1);
      idle(20);
      check("post_rst_ferr", frame_err, 0);
      pop_one();
      idle(2);
      check("final_empty", rx_valid, 0);
      check("queue_empty", 8'(exp_q.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
